// File: rtl/pe_window_feeder.sv
// pe_window_feeder
//
// Streaming operand feeder for the combinational pe datapath. Weights are
// loaded serially into a kernel register. Activation samples then slide
// through an N_REG-deep window, and every STRIDE samples the current window
// is presented to the PE together with the kernel.
//
// Optional feature: define PE_FEEDER_PAD_EN to zero-pad each frame with
// P = (N_REG-1)/2 samples at both ends ("same" convolution framing).
//
// Parameters
//   WIDTH   sample/weight word width (no arithmetic is done on data)
//   N_REG   kernel/window length, odd, >= 3
//   STRIDE  samples advanced between windows, 1..N_REG
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   w_valid/w_ready/w_data  weight stream (accepted only in IDLE)
//   s_valid/s_ready/s_data/s_last  activation stream, s_last ends the frame
//   m_valid/m_ready       window handshake
//   m_all_a               window, slice 0 = oldest sample
//   m_all_w               kernel, slice 0 = first weight of the last N_REG
//   frame_done            one-cycle pulse after the final shift of a frame
//   wts_ok                a full kernel has been loaded since reset
//   dbg_state             current FSM state (IDLE=0, STREAM=1, FLUSH=2)
//
// Handshake semantics (all three channels): a transfer happens on a rising
// clock edge where valid and ready are both high. A producer holds valid and
// data stable until the transfer; ready may depend combinationally on the
// consumer-side ready (s_ready follows m_ready), never on the same channel's
// valid.
module pe_window_feeder #(
   parameter int WIDTH  = 32,
   parameter int N_REG  = 31,
   parameter int STRIDE = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     w_valid,
   output logic                     w_ready,
   input  logic [WIDTH-1:0]         w_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [WIDTH-1:0]         s_data,
   input  logic                     s_last,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [N_REG*WIDTH-1:0]   m_all_a,
   output logic [N_REG*WIDTH-1:0]   m_all_w,
   output logic                     frame_done,
   output logic                     wts_ok,
   output logic [1:0]               dbg_state
);

   localparam int FW = $clog2(N_REG + 1);
   localparam int SW = $clog2(STRIDE + 1);
   localparam int AW = N_REG * WIDTH;
   localparam logic [FW-1:0] FULL    = FW'(N_REG);
   localparam logic [SW-1:0] ST_WRAP = SW'(STRIDE);
`ifdef PE_FEEDER_PAD_EN
   localparam int P  = (N_REG - 1) / 2;
   localparam int PW = $clog2(P + 1);
   localparam logic [PW-1:0] FLUSH_N   = PW'(P);
   localparam logic [FW-1:0] FILL_INIT = FW'(P);
`else
   localparam logic [FW-1:0] FILL_INIT = '0;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2} state_t;

   state_t              state;
   logic [AW-1:0]       win;
   logic [AW-1:0]       out_a;
   logic [AW-1:0]       w_reg;
   logic [FW-1:0]       fill;
   logic [SW-1:0]       st;
   logic [FW-1:0]       w_cnt;
   logic                m_valid_r;
   logic                wts_ok_r;
   logic                w_ready_r;
   logic                frame_done_r;
`ifdef PE_FEEDER_PAD_EN
   logic [PW-1:0]       flush_cnt;
`endif

   logic                s_fire;
   logic                w_fire;
   logic                flush_fire;
   logic                do_shift;
   logic                emit;
   logic [AW-1:0]       base_win;
   logic [AW-1:0]       shift_win;
   logic [FW-1:0]       base_fill;
   logic [FW-1:0]       shift_fill;
   logic [SW-1:0]       base_st;
   logic [SW-1:0]       shift_st;
   logic [SW-1:0]       st_inc;
   logic [WIDTH-1:0]    new_val;

   assign s_ready    = wts_ok_r & ((state == IDLE) | (state == STREAM)) & (~m_valid_r | m_ready);
   assign s_fire     = s_valid & s_ready;
   assign w_fire     = w_valid & w_ready_r;
`ifdef PE_FEEDER_PAD_EN
   assign flush_fire = (state == FLUSH) & (~m_valid_r | m_ready);
`else
   assign flush_fire = 1'b0;
`endif
   assign do_shift   = s_fire | flush_fire;

   // Next window contents and emission decision for a shift this cycle.
   // In IDLE the shift starts from a cleared window and fresh counters, so
   // frame initialisation and the first sample happen in the same cycle.
   always_comb begin
      base_win  = win;
      base_fill = fill;
      base_st   = st;
      if (state == IDLE) begin
         base_win  = '0;
         base_fill = FILL_INIT;
         base_st   = '0;
      end
      new_val    = (state == FLUSH) ? '0 : s_data;
      shift_win  = {new_val, base_win[AW-1:WIDTH]};
      shift_fill = base_fill;
      shift_st   = base_st;
      st_inc     = base_st + 1'b1;
      emit       = 1'b0;
      if (base_fill == FULL) begin
         // Window already full: emit every STRIDE shifts.
         if (st_inc == ST_WRAP) begin
            emit     = 1'b1;
            shift_st = '0;
         end else begin
            shift_st = st_inc;
         end
      end else begin
         shift_fill = base_fill + 1'b1;
         if (shift_fill == FULL) begin
            emit     = 1'b1;
            shift_st = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         win          <= '0;
         out_a        <= '0;
         w_reg        <= '0;
         fill         <= '0;
         st           <= '0;
         w_cnt        <= '0;
         m_valid_r    <= 1'b0;
         wts_ok_r     <= 1'b0;
         w_ready_r    <= 1'b0;
         frame_done_r <= 1'b0;
`ifdef PE_FEEDER_PAD_EN
         flush_cnt    <= '0;
`endif
      end else begin
         frame_done_r <= 1'b0;

         // Kernel load: newest word at the top, last N_REG words win.
         if (w_fire) begin
            w_reg <= {w_data, w_reg[AW-1:WIDTH]};
            if (w_cnt != FULL) w_cnt <= w_cnt + 1'b1;
            if (w_cnt == FULL - 1'b1) wts_ok_r <= 1'b1;
         end

         if (do_shift) begin
            win  <= shift_win;
            fill <= shift_fill;
            st   <= shift_st;
         end

         // A shift only happens when the output slot is free or draining,
         // so a new emission never overwrites an unconsumed window.
         if (do_shift && emit) begin
            out_a     <= shift_win;
            m_valid_r <= 1'b1;
         end else if (m_ready) begin
            m_valid_r <= 1'b0;
         end

         case (state)
            IDLE, STREAM: begin
               if (s_fire) begin
                  if (s_last) begin
`ifdef PE_FEEDER_PAD_EN
                     state     <= FLUSH;
                     flush_cnt <= FLUSH_N;
                     w_ready_r <= 1'b0;
`else
                     state        <= IDLE;
                     frame_done_r <= 1'b1;
                     w_ready_r    <= 1'b1;
`endif
                  end else begin
                     state     <= STREAM;
                     w_ready_r <= 1'b0;
                  end
               end else begin
                  w_ready_r <= (state == IDLE);
               end
            end
`ifdef PE_FEEDER_PAD_EN
            FLUSH: begin
               if (flush_fire) begin
                  flush_cnt <= flush_cnt - 1'b1;
                  if (flush_cnt == PW'(1)) begin
                     state        <= IDLE;
                     frame_done_r <= 1'b1;
                     w_ready_r    <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state     <= IDLE;
               w_ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign w_ready    = w_ready_r;
   assign m_valid    = m_valid_r;
   assign m_all_a    = out_a;
   assign m_all_w    = w_reg;
   assign frame_done = frame_done_r;
   assign wts_ok     = wts_ok_r;
   assign dbg_state  = state;

endmodule
